// File: rtl/nx_stream_combiner_pkg.sv
// Shared nexus definitions for the stream combiner.
//   nx_dir_e          : 2-bit message direction tag. The combiner passes it
//                       through untouched and never decodes it.
//   ARB_*             : legal values of the ARB_SCHEME parameter.
//   grant_e           : identifies the input that won the last transfer.
package nx_stream_combiner_pkg;

  typedef enum logic [1:0] {
    DIR_NONE = 2'd0,
    DIR_UP   = 2'd1,
    DIR_DOWN = 2'd2,
    DIR_BOTH = 2'd3
  } nx_dir_e;

  localparam string ARB_ROUND_ROBIN = "round_robin";
  localparam string ARB_PREFER_A    = "prefer_a";
  localparam string ARB_PREFER_B    = "prefer_b";

  typedef enum logic {
    GRANT_A = 1'b0,
    GRANT_B = 1'b1
  } grant_e;

endpackage

// File: rtl/nx_stream_combiner.sv
// Two-into-one message stream combiner with a single registered output slot.
//   clk_i, rst_i                       : clock, synchronous active-high reset
//   stream_a_{data,dir,valid}_i / _ready_o : input stream A handshake
//   stream_b_{data,dir,valid}_i / _ready_o : input stream B handshake
//   comb_{data,dir,valid}_o / comb_ready_i : combined output handshake
// ARB_SCHEME picks the contention winner: "round_robin", "prefer_a" or
// "prefer_b". An accepted message appears on comb_* one cycle later; full
// throughput is kept because the slot is also free when it is being drained.
module nx_stream_combiner
  import nx_stream_combiner_pkg::*;
#(
  parameter int    STREAM_WIDTH = 32,
  parameter string ARB_SCHEME   = ARB_ROUND_ROBIN
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [STREAM_WIDTH-1:0] stream_a_data_i,
  input  logic [1:0]              stream_a_dir_i,
  input  logic                    stream_a_valid_i,
  output logic                    stream_a_ready_o,
  input  logic [STREAM_WIDTH-1:0] stream_b_data_i,
  input  logic [1:0]              stream_b_dir_i,
  input  logic                    stream_b_valid_i,
  output logic                    stream_b_ready_o,
  output logic [STREAM_WIDTH-1:0] comb_data_o,
  output logic [1:0]              comb_dir_o,
  output logic                    comb_valid_o,
  input  logic                    comb_ready_i
);

  localparam bit IS_RR = (ARB_SCHEME == ARB_ROUND_ROBIN);
  localparam bit IS_PA = (ARB_SCHEME == ARB_PREFER_A);
  localparam bit IS_PB = (ARB_SCHEME == ARB_PREFER_B);

  if (!(IS_RR || IS_PA || IS_PB)) begin : g_bad_arb_scheme
    $error("nx_stream_combiner: illegal ARB_SCHEME value");
  end

  logic [STREAM_WIDTH-1:0] data_q, data_d;
  logic [1:0]              dir_q, dir_d;
  logic                    valid_q, valid_d;
  grant_e                  last_grant_q, last_grant_d;

  logic slot_free;
  logic grant_b;
  logic a_ready;
  logic b_ready;

  always_comb begin
    // Slot can take a new message if empty or being drained this cycle.
    slot_free = !valid_q || comb_ready_i;

    grant_b = 1'b0;
    if (stream_b_valid_i && !stream_a_valid_i) begin
      grant_b = 1'b1;
    end else if (stream_a_valid_i && stream_b_valid_i) begin
      if (IS_PB) begin
        grant_b = 1'b1;
      end else if (IS_RR) begin
        grant_b = (last_grant_q == GRANT_A);
      end
    end

    // Reset gates the readies so nothing looks accepted during reset.
    a_ready = !rst_i && slot_free && stream_a_valid_i && !grant_b;
    b_ready = !rst_i && slot_free && stream_b_valid_i &&  grant_b;

    data_d       = data_q;
    dir_d        = dir_q;
    valid_d      = valid_q;
    last_grant_d = last_grant_q;

    if (a_ready) begin
      data_d       = stream_a_data_i;
      dir_d        = stream_a_dir_i;
      valid_d      = 1'b1;
      last_grant_d = GRANT_A;
    end else if (b_ready) begin
      data_d       = stream_b_data_i;
      dir_d        = stream_b_dir_i;
      valid_d      = 1'b1;
      last_grant_d = GRANT_B;
    end else if (slot_free) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      data_q       <= '0;
      dir_q        <= '0;
      valid_q      <= 1'b0;
      // Recording B as last winner makes A win the first contention.
      last_grant_q <= GRANT_B;
    end else begin
      data_q       <= data_d;
      dir_q        <= dir_d;
      valid_q      <= valid_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign stream_a_ready_o = a_ready;
  assign stream_b_ready_o = b_ready;
  assign comb_data_o      = data_q;
  assign comb_dir_o       = dir_q;
  assign comb_valid_o     = valid_q;

endmodule

// File: tb/tb_nx_stream_combiner.sv
module tb_nx_stream_combiner;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [W-1:0] a_data = '0, b_data = '0;
  logic [1:0]   a_dir = '0, b_dir = '0;
  logic         a_valid = 1'b0, b_valid = 1'b0;
  logic         c_ready = 1'b0;

  logic         rr_a_rdy, rr_b_rdy, rr_vld;
  logic [W-1:0] rr_data;
  logic [1:0]   rr_dir;
  logic         pa_a_rdy, pa_b_rdy, pa_vld;
  logic [W-1:0] pa_data;
  logic [1:0]   pa_dir;
  logic         pb_a_rdy, pb_b_rdy, pb_vld;
  logic [W-1:0] pb_data;
  logic [1:0]   pb_dir;

  always #5 clk = ~clk;

  nx_stream_combiner #(.STREAM_WIDTH(W), .ARB_SCHEME("round_robin")) u_rr (
    .clk_i(clk), .rst_i(rst),
    .stream_a_data_i(a_data), .stream_a_dir_i(a_dir), .stream_a_valid_i(a_valid), .stream_a_ready_o(rr_a_rdy),
    .stream_b_data_i(b_data), .stream_b_dir_i(b_dir), .stream_b_valid_i(b_valid), .stream_b_ready_o(rr_b_rdy),
    .comb_data_o(rr_data), .comb_dir_o(rr_dir), .comb_valid_o(rr_vld), .comb_ready_i(c_ready));

  nx_stream_combiner #(.STREAM_WIDTH(W), .ARB_SCHEME("prefer_a")) u_pa (
    .clk_i(clk), .rst_i(rst),
    .stream_a_data_i(a_data), .stream_a_dir_i(a_dir), .stream_a_valid_i(a_valid), .stream_a_ready_o(pa_a_rdy),
    .stream_b_data_i(b_data), .stream_b_dir_i(b_dir), .stream_b_valid_i(b_valid), .stream_b_ready_o(pa_b_rdy),
    .comb_data_o(pa_data), .comb_dir_o(pa_dir), .comb_valid_o(pa_vld), .comb_ready_i(c_ready));

  nx_stream_combiner #(.STREAM_WIDTH(W), .ARB_SCHEME("prefer_b")) u_pb (
    .clk_i(clk), .rst_i(rst),
    .stream_a_data_i(a_data), .stream_a_dir_i(a_dir), .stream_a_valid_i(a_valid), .stream_a_ready_o(pb_a_rdy),
    .stream_b_data_i(b_data), .stream_b_dir_i(b_dir), .stream_b_valid_i(b_valid), .stream_b_ready_o(pb_b_rdy),
    .comb_data_o(pb_data), .comb_dir_o(pb_dir), .comb_valid_o(pb_vld), .comb_ready_i(c_ready));

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
  endtask

  // Inputs change 1 ns after the rising edge; checks run 1 ns after that.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic av, input logic [W-1:0] ad, input logic [1:0] adr,
                       input logic bv, input logic [W-1:0] bd, input logic [1:0] bdr,
                       input logic cr);
    a_valid = av; a_data = ad; a_dir = adr;
    b_valid = bv; b_data = bd; b_dir = bdr;
    c_ready = cr;
    #1;
  endtask

  logic [W+1:0] sb_q[$];
  logic [W+1:0] exp_e;
  logic [W-1:0] exp_rr, exp_pa, exp_pb;
  logic         exp_rr_from_a;
  int           ia, ib;

  initial begin
    // Reset with inputs asserted: readies must stay low.
    rst = 1'b1;
    drive(1, 32'h99, 2'd2, 1, 32'h98, 2'd3, 1);
    chk("rst_a_ready", rr_a_rdy, 0);
    chk("rst_b_ready", rr_b_rdy, 0);
    tick();
    tick();
    chk("rst_valid", rr_vld, 0);
    chk("rst_data", rr_data, 0);
    chk("rst_dir", rr_dir, 0);

    // Single message from A.
    rst = 1'b0;
    drive(1, 32'h11, 2'd1, 0, 32'h0, 2'd0, 1);
    chk("single_a_ready", rr_a_rdy, 1);
    chk("single_b_ready", rr_b_rdy, 0);
    tick();
    chk("single_data", rr_data, 32'h11);
    chk("single_dir", rr_dir, 1);
    chk("single_valid", rr_vld, 1);
    drive(0, 32'h0, 2'd0, 0, 32'h0, 2'd0, 1);
    tick();
    chk("idle_valid_drop", rr_vld, 0);

    // Fresh reset so A wins the first contention, then both streams busy.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    ia = 0; ib = 0;
    for (int n = 0; n < 8; n++) begin
      drive(1, 32'hA0 + ia, 2'd2, 1, 32'hB0 + ib, 2'd3, 1);
      exp_rr_from_a = (n % 2 == 0);
      chk("rr_a_ready", rr_a_rdy, exp_rr_from_a);
      chk("rr_b_ready", rr_b_rdy, !exp_rr_from_a);
      chk("pa_a_ready", pa_a_rdy, 1);
      chk("pa_b_ready", pa_b_rdy, 0);
      chk("pb_a_ready", pb_a_rdy, 0);
      chk("pb_b_ready", pb_b_rdy, 1);
      exp_rr = exp_rr_from_a ? 32'hA0 + ia : 32'hB0 + ib;
      exp_pa = a_data;
      exp_pb = b_data;
      tick();
      chk("rr_order_data", rr_data, exp_rr);
      chk("rr_order_dir", rr_dir, exp_rr_from_a ? 2'd2 : 2'd3);
      chk("rr_order_valid", rr_vld, 1);
      chk("pa_data", pa_data, exp_pa);
      chk("pb_data", pb_data, exp_pb);
      if (exp_rr_from_a) ia++; else ib++;
    end

    // Load 0x55 from A, then stall downstream for 5 cycles.
    drive(1, 32'h55, 2'd1, 0, 32'h0, 2'd0, 1);
    tick();
    for (int n = 0; n < 5; n++) begin
      drive(1, 32'h66, 2'd2, 1, 32'h77, 2'd3, 0);
      chk("stall_data", rr_data, 32'h55);
      chk("stall_dir", rr_dir, 1);
      chk("stall_valid", rr_vld, 1);
      chk("stall_a_ready", rr_a_rdy, 0);
      chk("stall_b_ready", rr_b_rdy, 0);
      tick();
    end
    drive(1, 32'h66, 2'd2, 1, 32'h77, 2'd3, 1);
    chk("unstall_b_ready", rr_b_rdy, 1);
    chk("unstall_a_ready", rr_a_rdy, 0);
    tick();
    chk("unstall_data", rr_data, 32'h77);
    chk("unstall_valid", rr_vld, 1);
    drive(1, 32'h66, 2'd2, 0, 32'h0, 2'd0, 1);
    tick();
    chk("after_unstall_data", rr_data, 32'h66);
    chk("after_unstall_dir", rr_dir, 2);

    // Reset while a message is held.
    rst = 1'b1;
    drive(1, 32'h12, 2'd1, 1, 32'h34, 2'd2, 0);
    chk("midrst_a_ready", rr_a_rdy, 0);
    chk("midrst_b_ready", rr_b_rdy, 0);
    tick();
    chk("midrst_valid", rr_vld, 0);
    chk("midrst_data", rr_data, 0);
    chk("midrst_dir", rr_dir, 0);
    rst = 1'b0;
    drive(1, 32'h12, 2'd1, 1, 32'h34, 2'd2, 1);
    chk("midrst_a_wins", rr_a_rdy, 1);
    tick();
    chk("midrst_next_data", rr_data, 32'h12);
    drive(0, 32'h0, 2'd0, 0, 32'h0, 2'd0, 1);
    tick();

    // Random traffic against a FIFO scoreboard on the round-robin instance.
    sb_q.delete();
    for (int n = 0; n < 400; n++) begin
      drive($urandom_range(0, 1), $urandom, 2'($urandom_range(0, 3)),
            $urandom_range(0, 1), $urandom, 2'($urandom_range(0, 3)),
            $urandom_range(0, 3) != 0);
      if (rr_a_rdy && rr_b_rdy) chk("rand_one_ready", 1, 0);
      if (rr_vld && c_ready) begin
        if (sb_q.size() == 0) chk("rand_unexpected_out", rr_data, 0);
        else begin
          exp_e = sb_q.pop_front();
          chk("rand_data", rr_data, exp_e[W-1:0]);
          chk("rand_dir", rr_dir, exp_e[W+1:W]);
        end
      end
      if (rr_a_rdy) sb_q.push_back({a_dir, a_data});
      if (rr_b_rdy) sb_q.push_back({b_dir, b_data});
      tick();
    end
    for (int n = 0; n < 3; n++) begin
      drive(0, 32'h0, 2'd0, 0, 32'h0, 2'd0, 1);
      if (rr_vld) begin
        if (sb_q.size() == 0) chk("drain_unexpected_out", rr_data, 0);
        else begin
          exp_e = sb_q.pop_front();
          chk("drain_data", rr_data, exp_e[W-1:0]);
          chk("drain_dir", rr_dir, exp_e[W+1:W]);
        end
      end
      tick();
    end
    chk("scoreboard_empty", sb_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/nx_stream_combiner.md
NX_STREAM_COMBINER -- requirements
Module: nx_stream_combiner

Interface
REQ-001 SHALL have parameter STREAM_WIDTH, default 32, giving the message data width in bits.
REQ-002 SHALL have parameter ARB_SCHEME, default "round_robin", selecting arbitration; legal values are "round_robin", "prefer_a" and "prefer_b".
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 clk_i  input  1  clock; all state changes on its rising edge.
REQ-005 rst_i  input  1  synchronous active-high reset.
REQ-006 stream_a_data_i  input  STREAM_WIDTH  stream A message payload.
REQ-007 stream_a_dir_i  input  2  stream A message direction tag.
REQ-008 stream_a_valid_i  input  1  stream A message present.
REQ-009 stream_a_ready_o  output  1  stream A message accepted this cycle.
REQ-010 stream_b_data_i / stream_b_dir_i / stream_b_valid_i / stream_b_ready_o SHALL mirror REQ-006..009 for stream B.
REQ-011 comb_data_o  output  STREAM_WIDTH  combined message payload.
REQ-012 comb_dir_o  output  2  combined message direction tag.
REQ-013 comb_valid_o  output  1  combined message present.
REQ-014 comb_ready_i  input  1  downstream accepts the combined message.

Function
REQ-015 Transfer on any stream SHALL occur when valid and ready are both high at a rising clock edge.
REQ-016 comb_data_o, comb_dir_o and comb_valid_o SHALL be driven from registers; no combinational path from inputs to these outputs.
REQ-017 Output slot SHALL be free when comb_valid_o is low or comb_ready_i is high.
REQ-018 stream_x_ready_o SHALL be high only when the slot is free, stream_x_valid_i is high and stream x holds the grant; at most one ready is high per cycle.
REQ-019 With only one input valid and the slot free, that input SHALL be granted.
REQ-020 With both inputs valid under "round_robin", the input not granted most recently SHALL be granted; the last-grant record SHALL update only on an accepted transfer.
REQ-021 Under "prefer_a", A SHALL win every contention; under "prefer_b", B SHALL win every contention.
REQ-022 An accepted message SHALL appear on comb_* on the next cycle, with data and dir passed through unmodified (latency 1 cycle).
REQ-023 Sustained throughput SHALL be one message per cycle when comb_ready_i is held high.
REQ-024 If the slot is free and no input is accepted, comb_valid_o SHALL drop to 0 on the next cycle.
REQ-025 While comb_valid_o is high and comb_ready_i is low, comb_data_o and comb_dir_o SHALL remain stable and both input readys SHALL be 0.
REQ-026 Input valid is not required to stay asserted; an un-accepted message carries no state.
REQ-027 Any ARB_SCHEME value outside REQ-002 SHALL cause an elaboration error.

Reset
REQ-028 While rst_i is high at a clock edge: comb_valid_o becomes 0, comb_data_o becomes 0, comb_dir_o becomes 0, and the last-grant record becomes B, so A wins the first contention.
REQ-029 During reset, both stream ready outputs SHALL be 0; a message held in comb_* when reset is asserted mid-operation SHALL be discarded.

Structure
REQ-030 The 2-bit direction encoding and the ARB_SCHEME string constants SHALL live in the shared nexus package; this block treats dir as opaque.
REQ-031 The block SHALL be a single module with no sub-modules; the arbiter is inline logic.

Verification
REQ-032 Reset, then A valid with data 0x11, dir 1, and comb_ready_i=1 -> stream_a_ready_o=1 that cycle; comb_* = 0x11/1/valid on the next cycle.
REQ-033 Round_robin, A and B both continuously valid (A=0xA0+n, B=0xB0+n), comb_ready_i=1 -> output order A0,B0,A1,B1,...; A is first after reset.
REQ-034 Prefer_a, both continuously valid -> only A is accepted and stream_b_ready_o stays 0; with prefer_b, the mirror result.
REQ-035 comb holds 0x55 with comb_ready_i=0 for 5 cycles and both inputs valid -> comb_* stable, both readys 0; when comb_ready_i rises, the next message follows one cycle later with no bubble.
REQ-036 Assert rst_i while comb_valid_o=1 -> next cycle comb_valid_o=0, data 0, dir 0, and the round-robin record resets so A wins next.
REQ-037 Random valid/ready stimulus on all three streams -> every accepted input message appears exactly once, in acceptance order, with matching data and dir.
